adc_stream_capture: RTL
=======================

// Module: adc_stream_capture
// PURPOSE
//  AXI-Stream sink and capture buffer; the receive-side counterpart of the DAC streamer.
//  Each AXIS beat carries SAMPLES_PER_CLOCK ADC samples. On the first EVR heartbeat edge
//  after arming, captures LAST_IDX+1 beats into a dual-port RAM. Software then reads the
//  buffer back one sample at a time over the GPIO/CSR bus.
// PARAMETERS
//  BUS_WIDTH          32   GPIO data/CSR width.
//  AXIS_DATA_WIDTH    256  AXIS beat width.
//  ADC_DATA_WIDTH     16   Bits per sample.
//  ADC_ADDRESS_WIDTH  14   Sample-address width (buffer depth = 2**14 samples).
//  Derived: SPC = AXIS_DATA_WIDTH/ADC_DATA_WIDTH (16); LANE_W = $clog2(SPC) (4);
//           WORD_AW = ADC_ADDRESS_WIDTH - LANE_W (10).
// PORTS
//  sysClk            in   1          Single clock; all ports synchronous to it.
//  sysReset          in   1          Synchronous, active-high reset.
//  sysGpioData       in   BUS_WIDTH  Write data for the address/control strobes.
//  sysAddressStrobe  in   1          Load readback sample address = sysGpioData[ADC_ADDRESS_WIDTH-1:0].
//  sysGpioStrobe     in   1          Control write; decoded only when sysGpioData[31]=1.
//  sysGpioCsr        out  BUS_WIDTH  Status word.
//  sysReadData       out  BUS_WIDTH  Selected sample, sign-extended to BUS_WIDTH.
//  evrHbMarker       in   1          Heartbeat level, already synchronous to sysClk.
//  axis_TDATA        in   AXIS_DATA_WIDTH  Sample k in bits [k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH].
//  axis_TVALID       in   1          Beat valid.
//  axis_TREADY       out  1          Sink ready.
// BEHAVIOUR
//  Reset values: sysGpioCsr=0, sysReadData=0, axis_TREADY=0, state=IDLE, lastIdx=0,
//   rdAddr=0. RAM contents are not cleared.
//  axis_TREADY = !sysReset, registered (1 from the first cycle after reset deasserts).
//   Beats accepted outside CAPTURE are discarded. The upstream stream is never stalled.
//  Control write (sysGpioStrobe && data[31]): bit0 ARM, bit1 ABORT;
//   lastIdx <= data[8 +: WORD_AW] on every control write.
//  Heartbeat edge: hbEdge = evrHbMarker && !hbPrev. hbPrev is registered and resets to 0.
//  State machine:
//   IDLE    -> ARMED    on ARM.
//   ARMED   -> CAPTURE  on hbEdge. wrIdx <= 0. Ignores a beat in the hbEdge cycle.
//   CAPTURE: each TVALID&&TREADY writes TDATA at word wrIdx and increments wrIdx.
//    The beat written at wrIdx==lastIdx moves the state to DONE.
//   DONE    -> ARMED    on ARM (done flag cleared).
//   Any state -> IDLE on ABORT (ABORT wins over ARM when both are set).
//  Edge cases:
//   - ARM and hbEdge in the same cycle: only the ARM transition happens. A later edge starts capture.
//   - hbEdge during CAPTURE or DONE is ignored (no retrigger).
//   - lastIdx==0 captures exactly 1 beat. lastIdx==2**WORD_AW-1 fills the whole buffer; wrIdx wraps to 0 unused.
//   - lastIdx written during CAPTURE takes effect at once. If wrIdx is already above the new
//     value, capture continues to the wrap point and then to lastIdx (software must not do this).
//   - sysReset mid-capture: state returns to IDLE; partial data stays in RAM.
//  Readback: sysAddressStrobe at cycle N loads rdAddr. The RAM reads word rdAddr[ADC_ADDRESS_WIDTH-1:LANE_W].
//   Lane rdAddr[LANE_W-1:0] is muxed out. sysReadData is valid and registered from cycle N+2.
//   Readback works in every state, but the data is defined only in DONE.
//  sysGpioCsr: [0]=ARMED|CAPTURE (busy), [1]=DONE, [2]=gap flag (see CONFIGURATION),
//   [7:3]=0, [8 +: WORD_AW]=lastIdx, remaining bits 0.
// CONFIGURATION
//  ADC_CAPTURE_GAP_DETECT_EN defined:
//   - CSR[2] is set on any CAPTURE cycle with axis_TVALID=0, i.e. the record is not contiguous.
//   - The flag is cleared on ARM and on reset.
//   - CSR[31:24] = saturating count of such gap cycles (requires WORD_AW<=16).
//  Not defined: CSR[2]=0, CSR[31:24]=0, and no counter logic is built.
// TESTING
//  T1: lastIdx=3, ARM, TVALID=1 continuous, beat n lane k = n*16+k, hbEdge
//      -> DONE after 4 beats; read address 37 -> sysReadData=37 two cycles later.
//  T2: ARM and hbEdge in the same cycle, next hbEdge 100 cycles later
//      -> capture starts only at the second edge; first stored word is the beat after it.
//  T3: CAPTURE at wrIdx=2, ABORT -> CSR[1:0]=00 next cycle; further beats are not written
//      (address 2*16 still holds the old data).
//  T4: lastIdx=1023, full-buffer capture -> DONE after 1024 beats; address 16383 returns lane 15 of beat 1023.
//  T5: TVALID low for 5 cycles during CAPTURE (GAP_DETECT_EN defined)
//      -> CSR[2]=1, CSR[31:24]=5; re-ARM clears both.
//  T6: sysReset asserted mid-capture -> all outputs 0 the next cycle; ARM plus hbEdge recapture correctly.

Source files
------------

// File: rtl/adc_stream_capture.sv
// adc_stream_capture
//   AXI-Stream sink with a one-shot capture buffer. After software arms the block,
//   the first EVR heartbeat rising edge starts a capture of lastIdx+1 AXIS beats
//   (SPC samples each) into a word-wide RAM. Software reads the buffer back one
//   sample at a time: an address strobe selects a sample, and the sign-extended
//   value appears on sysReadData two cycles later.
//
// Optional feature (compile-time macro ADC_CAPTURE_GAP_DETECT_EN):
//   when defined, CSR[2] flags any CAPTURE cycle without axis_TVALID and
//   CSR[31:24] holds a saturating count of those cycles. Both clear on ARM.
//
// Ports
//   sysClk, sysReset   single clock, synchronous active-high reset
//   sysGpioData        write data for both strobes
//   sysAddressStrobe   load readback sample address from sysGpioData
//   sysGpioStrobe      control write when sysGpioData[31]=1 (bit0 ARM, bit1 ABORT,
//                      [8 +: WORD_AW] lastIdx)
//   sysGpioCsr         status: [0] busy, [1] done, [2] gap, [8 +: WORD_AW] lastIdx,
//                      [31:24] gap count
//   sysReadData        selected sample, sign-extended
//   evrHbMarker        heartbeat level (already in sysClk domain)
//   axis_TDATA/TVALID  stream input, sample k at [k*ADC_DATA_WIDTH +: ADC_DATA_WIDTH]
//   axis_TREADY        always ready once out of reset
module adc_stream_capture #(
  parameter int BUS_WIDTH         = 32,
  parameter int AXIS_DATA_WIDTH   = 256,
  parameter int ADC_DATA_WIDTH    = 16,
  parameter int ADC_ADDRESS_WIDTH = 14
) (
  input  logic                       sysClk,
  input  logic                       sysReset,
  input  logic [BUS_WIDTH-1:0]       sysGpioData,
  input  logic                       sysAddressStrobe,
  input  logic                       sysGpioStrobe,
  output logic [BUS_WIDTH-1:0]       sysGpioCsr,
  output logic [BUS_WIDTH-1:0]       sysReadData,
  input  logic                       evrHbMarker,
  input  logic [AXIS_DATA_WIDTH-1:0] axis_TDATA,
  input  logic                       axis_TVALID,
  output logic                       axis_TREADY
);

  localparam int SPC     = AXIS_DATA_WIDTH / ADC_DATA_WIDTH;
  localparam int LANE_W  = $clog2(SPC);
  localparam int WORD_AW = ADC_ADDRESS_WIDTH - LANE_W;
  localparam int DEPTH   = 2 ** WORD_AW;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t                         state_q, state_d;
  logic [WORD_AW-1:0]             last_idx_q, last_idx_d;
  logic [WORD_AW-1:0]             wr_idx_q, wr_idx_d;
  logic                           hb_prev_q, hb_prev_d;
  logic                           tready_q, tready_d;
  logic [ADC_ADDRESS_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [BUS_WIDTH-1:0]           read_data_q, read_data_d;

  logic [AXIS_DATA_WIDTH-1:0]     ram [DEPTH];
  logic                           ram_we;

  logic ctl_wr, arm, abort_cmd, hb_edge, beat;
  logic [WORD_AW-1:0]             rd_word;
  logic [LANE_W-1:0]              rd_lane;
  logic [AXIS_DATA_WIDTH-1:0]     rd_ram_word;
  logic [ADC_DATA_WIDTH-1:0]      rd_sample;

  // Bits of sysGpioData that neither strobe decodes.
  logic unused_gpio_bits;
  assign unused_gpio_bits = ^sysGpioData[BUS_WIDTH-2:8+WORD_AW];

  assign ctl_wr    = sysGpioStrobe && sysGpioData[BUS_WIDTH-1];
  assign arm       = ctl_wr && sysGpioData[0];
  assign abort_cmd = ctl_wr && sysGpioData[1];
  assign hb_edge   = evrHbMarker && !hb_prev_q;
  assign beat      = axis_TVALID && tready_q;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    last_idx_d = ctl_wr ? sysGpioData[8 +: WORD_AW] : last_idx_q;
    ram_we     = 1'b0;
    hb_prev_d  = evrHbMarker;
    tready_d   = 1'b1;
    rd_addr_d  = sysAddressStrobe ? sysGpioData[ADC_ADDRESS_WIDTH-1:0] : rd_addr_q;

    unique case (state_q)
      ST_IDLE:  if (arm) state_d = ST_ARMED;
      // A fresh ARM in the same cycle as the edge keeps us armed; the edge is consumed.
      ST_ARMED: if (hb_edge && !arm) begin
        state_d  = ST_CAPTURE;
        wr_idx_d = '0;
      end
      ST_CAPTURE: if (beat) begin
        ram_we   = 1'b1;
        wr_idx_d = wr_idx_q + 1'b1;
        if (wr_idx_q == last_idx_q) state_d = ST_DONE;
      end
      ST_DONE:  if (arm) state_d = ST_ARMED;
      default:  state_d = ST_IDLE;
    endcase

    if (abort_cmd) begin
      state_d = ST_IDLE;
      ram_we  = 1'b0;
    end
    if (sysReset) ram_we = 1'b0;
  end

  // Readback: rd_addr_q selects word and lane; the muxed sample is registered.
  always_comb begin
    rd_word     = rd_addr_q[ADC_ADDRESS_WIDTH-1:LANE_W];
    rd_lane     = rd_addr_q[LANE_W-1:0];
    rd_ram_word = ram[rd_word];
    rd_sample   = rd_ram_word[int'(rd_lane)*ADC_DATA_WIDTH +: ADC_DATA_WIDTH];
    read_data_d = {{(BUS_WIDTH-ADC_DATA_WIDTH){rd_sample[ADC_DATA_WIDTH-1]}}, rd_sample};
  end

  always_ff @(posedge sysClk) begin
    if (ram_we) ram[wr_idx_q] <= axis_TDATA;
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      state_q     <= ST_IDLE;
      last_idx_q  <= '0;
      wr_idx_q    <= '0;
      hb_prev_q   <= 1'b0;
      tready_q    <= 1'b0;
      rd_addr_q   <= '0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      last_idx_q  <= last_idx_d;
      wr_idx_q    <= wr_idx_d;
      hb_prev_q   <= hb_prev_d;
      tready_q    <= tready_d;
      rd_addr_q   <= rd_addr_d;
      read_data_q <= read_data_d;
    end
  end

`ifdef ADC_CAPTURE_GAP_DETECT_EN
  logic       gap_flag_q, gap_flag_d;
  logic [7:0] gap_cnt_q, gap_cnt_d;

  always_comb begin
    gap_flag_d = gap_flag_q;
    gap_cnt_d  = gap_cnt_q;
    if (arm) begin
      gap_flag_d = 1'b0;
      gap_cnt_d  = '0;
    end else if (state_q == ST_CAPTURE && !axis_TVALID) begin
      gap_flag_d = 1'b1;
      if (gap_cnt_q != '1) gap_cnt_d = gap_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge sysClk) begin
    if (sysReset) begin
      gap_flag_q <= 1'b0;
      gap_cnt_q  <= '0;
    end else begin
      gap_flag_q <= gap_flag_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end
`endif

  always_comb begin
    sysGpioCsr              = '0;
    sysGpioCsr[0]           = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
    sysGpioCsr[1]           = (state_q == ST_DONE);
    sysGpioCsr[8 +: WORD_AW] = last_idx_q;
`ifdef ADC_CAPTURE_GAP_DETECT_EN
    sysGpioCsr[2]                 = gap_flag_q;
    sysGpioCsr[BUS_WIDTH-1 -: 8]  = gap_cnt_q;
`endif
  end

  assign sysReadData = read_data_q;
  assign axis_TREADY = tready_q;

endmodule
